// File: rtl/xgriscv_alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helper for the xgriscv
// execute unit.
package xgriscv_alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_GE     = 5'h0A;
  localparam logic [4:0] OP_GEU    = 5'h0B;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // 0x10-0x17: bit 2 selects divide, bit 1 selects remainder within divide.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/xgriscv_muldiv_iter.sv
// Iterative 1-bit/cycle shift-add multiplier and restoring divider sharing
// one accumulator, one operand register and a down-counter.
module xgriscv_muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN:0]   a,
  input  logic [XLEN:0]   b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic              run, div_m;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] p;      // mul: partial product; div: {rem, quotient/dividend}
  logic [2*XLEN-1:0] m;      // mul: shifted multiplicand; div: divisor in low half
  logic [XLEN:0]     q;      // multiplier bits, consumed LSB first

  logic [2*XLEN-1:0] p_mul, p_div, p_nxt;
  logic [XLEN:0]     rt, diff;
  logic              last;

  assign last = (cnt == '0);

  always_comb begin
    p_mul = p + (q[0] ? m : '0);
    // Multiplier bit XLEN carries weight -2^XLEN in two's complement.
    if (last && q[1]) p_mul = p_mul - {m[2*XLEN-2:0], 1'b0};
  end

  // Remainder with the next dividend bit shifted in; borrow means rt < divisor.
  assign rt    = p[2*XLEN-1:XLEN-1];
  assign diff  = rt - {1'b0, m[XLEN-1:0]};
  assign p_div = diff[XLEN] ? {rt[XLEN-1:0], p[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};

  assign p_nxt = div_m ? p_div : p_mul;
  assign done  = run && last;
  assign hi    = p_nxt[2*XLEN-1:XLEN];
  assign lo    = p_nxt[XLEN-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run   <= 1'b0;
      div_m <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      m     <= '0;
      q     <= '0;
    end else if (flush) begin
      run <= 1'b0;
    end else if (start) begin
      run   <= 1'b1;
      div_m <= is_div;
      cnt   <= CNT_W'(XLEN - 1);
      p     <= is_div ? {{XLEN{1'b0}}, a[XLEN-1:0]} : '0;
      m     <= is_div ? {{XLEN{1'b0}}, b[XLEN-1:0]} : {{(XLEN-1){a[XLEN]}}, a};
      q     <= b;
    end else if (run) begin
      p   <= p_nxt;
      m   <= div_m ? m : {m[2*XLEN-2:0], 1'b0};
      q   <= q >> 1;
      cnt <= cnt - CNT_W'(1);
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/xgriscv_muldiv_alu.sv
// EX-stage execute unit: single-cycle integer ALU plus iterative M-extension,
// valid/ready handshaked with a registered, held result.
module xgriscv_muldiv_alu
  import xgriscv_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            busy
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [4:0]      op_r;
  logic            neg_q, neg_r;

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s, lt_u;
  logic [XLEN-1:0]    alu_res, spec_res, imm_res, fin_res, a_mag, b_mag;
  logic               a_sgn_op, b_sgn_op, sa, sb, is_div_op, is_rem, div0, ovf, special;
  logic               start, it_done;
  logic [XLEN:0]      it_a, it_b;
  logic [XLEN-1:0]    it_hi, it_lo;

  assign shamt = in_b[SHAMT_W-1:0];
  assign lt_s  = $signed(in_a) < $signed(in_b);
  assign lt_u  = in_a < in_b;

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $signed(in_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_GE:   alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_GEU:  alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
      default: alu_res = '0;
    endcase
  end

  // Operand signedness per op; MUL treats b as unsigned since the low half is
  // the same either way.
  assign a_sgn_op  = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                     (in_op == OP_DIV) || (in_op == OP_REM);
  assign b_sgn_op  = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
  assign sa        = a_sgn_op & in_a[XLEN-1];
  assign sb        = b_sgn_op & in_b[XLEN-1];
  assign a_mag     = sa ? -in_a : in_a;
  assign b_mag     = sb ? -in_b : in_b;

  assign is_div_op = is_muldiv(in_op) && in_op[2];
  assign is_rem    = in_op[1];
  assign div0      = (in_b == '0);
  assign ovf       = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == XMIN) && (&in_b);
  assign special   = is_div_op && (div0 || ovf);

  always_comb begin
    spec_res = '0;
    if (div0)     spec_res = is_rem ? in_a : '1;
    else if (ovf) spec_res = is_rem ? '0 : in_a;
  end

  assign imm_res = special ? spec_res : alu_res;
  assign it_a    = is_div_op ? {1'b0, a_mag} : {sa, in_a};
  assign it_b    = is_div_op ? {1'b0, b_mag} : {sb, in_b};
  assign start   = (state == S_IDLE) && in_valid && !flush && is_muldiv(in_op) && !special;

  xgriscv_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (start),
    .is_div (is_div_op),
    .a      (it_a),
    .b      (it_b),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  always_comb begin
    if (op_r[2]) fin_res = op_r[1] ? (neg_r ? -it_hi : it_hi) : (neg_q ? -it_lo : it_lo);
    else         fin_res = (op_r == OP_MUL) ? it_lo : it_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
      op_r       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else if (flush) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_r     <= in_op;
          neg_q    <= sa ^ sb;
          neg_r    <= sa;
          in_ready <= 1'b0;
          if (start) begin
            state <= in_op[2] ? S_DIV : S_MUL;
            busy  <= 1'b1;
          end else begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            out_result <= imm_res;
            out_zero   <= (imm_res == '0);
          end
        end
        S_MUL, S_DIV: if (it_done) begin
          state      <= S_DONE;
          busy       <= 1'b0;
          out_valid  <= 1'b1;
          out_result <= fin_res;
          out_zero   <= (fin_res == '0);
        end
        S_DONE: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xgriscv_muldiv_alu.sv
// Scoreboard bench for xgriscv_muldiv_alu: 32-bit and 64-bit instances driven
// with directed vectors; monitors pop expectations on each new result.
module tb_xgriscv_muldiv_alu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        flush, in_valid, in_ready, out_valid, out_ready, out_zero, busy;
  logic [4:0]  in_op;
  logic [31:0] in_a, in_b, out_result;

  logic        flush6, in_valid6, in_ready6, out_valid6, out_ready6, out_zero6, busy6;
  logic [4:0]  in_op6;
  logic [63:0] in_a6, in_b6, out_result6;

  xgriscv_muldiv_alu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .busy(busy));

  xgriscv_muldiv_alu #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush6), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_op(in_op6), .in_a(in_a6), .in_b(in_b6), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_result(out_result6), .out_zero(out_zero6), .busy(busy6));

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          bsy;
    int          acc;
    string       nm;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Monitors: compare on the first cycle a result is presented.
  initial begin
    bit seen = 0;
    int bc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_ready) bc = 0;
      if (busy) bc++;
      if (out_valid && !seen) begin
        seen = 1;
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid32: got result %h, expected no result", out_result);
        end else begin
          e = q32.pop_front();
          chk({e.nm, " result"}, 64'(out_result), e.res);
          chk({e.nm, " zero"}, 64'(out_zero), 64'(e.res == 0));
          chk({e.nm, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
          chk({e.nm, " busy_cycles"}, 64'(bc), 64'(e.bsy));
        end
      end
      if (!out_valid) seen = 0;
    end
  end

  initial begin
    bit seen = 0;
    int bc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_ready6) bc = 0;
      if (busy6) bc++;
      if (out_valid6 && !seen) begin
        seen = 1;
        if (q64.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid64: got result %h, expected no result", out_result6);
        end else begin
          e = q64.pop_front();
          chk({e.nm, " result"}, out_result6, e.res);
          chk({e.nm, " zero"}, 64'(out_zero6), 64'(e.res == 0));
          chk({e.nm, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
          chk({e.nm, " busy_cycles"}, 64'(bc), 64'(e.bsy));
        end
      end
      if (!out_valid6) seen = 0;
    end
  end

  task automatic issue32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input int bsy,
                         input string nm, input bit exp_out = 1'b1);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin fail_now({nm, " accept32"}); return; end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    if (exp_out) begin
      e.res = 64'(res); e.lat = lat; e.bsy = bsy; e.acc = cyc + 1; e.nm = nm;
      q32.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0; in_op = 5'h1F; in_a = $urandom; in_b = $urandom;
  endtask

  task automatic issue64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input int lat, input int bsy, input string nm);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready6 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready6) begin fail_now({nm, " accept64"}); return; end
    in_valid6 = 1'b1; in_op6 = op; in_a6 = a; in_b6 = b;
    e.res = res; e.lat = lat; e.bsy = bsy; e.acc = cyc + 1; e.nm = nm;
    q64.push_back(e);
    @(negedge clk);
    in_valid6 = 1'b0; in_op6 = 5'h1F; in_a6 = {$urandom, $urandom}; in_b6 = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0 || !in_ready || !in_ready6) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) fail_now("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    flush6 = 1'b0; in_valid6 = 1'b0; in_op6 = '0; in_a6 = '0; in_b6 = '0; out_ready6 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_result", 64'(out_result), 64'd0);
    chk("reset out_zero", 64'(out_zero), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Base ops: latency 1, no busy cycles.
    issue32(5'h00, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0, "ADD_wrap");
    issue32(5'h01, 32'd5,        32'd5,        32'h0,        1, 0, "SUB_zero");
    issue32(5'h07, 32'h80000000, 32'd4,        32'hF8000000, 1, 0, "SRA");
    issue32(5'h06, 32'h80000000, 32'h24,       32'h08000000, 1, 0, "SRL_shamt_mask");
    issue32(5'h05, 32'h1,        32'h3F,       32'h80000000, 1, 0, "SLL_31");
    issue32(5'h08, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, "SLT");
    issue32(5'h09, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, "SLTU");
    issue32(5'h0A, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, "GE");
    issue32(5'h0B, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, "GEU");
    issue32(5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, "XOR");
    issue32(5'h0C, 32'h12345678, 32'h1,        32'h0,        1, 0, "unknown_op");

    // Multiply: latency XLEN+1, busy XLEN cycles.
    issue32(5'h10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 33, 32, "MUL");
    issue32(5'h11, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 32, "MULH");
    issue32(5'h12, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 32, "MULHSU");
    issue32(5'h13, 32'hFFFFFFFF, 32'd2,        32'h00000001, 33, 32, "MULHU");
    issue32(5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 33, 32, "MULH_min");
    issue32(5'h12, 32'h80000000, 32'h80000000, 32'hC0000000, 33, 32, "MULHSU_min");

    // Divide, including the single-cycle special cases.
    issue32(5'h14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 32, "DIV_neg");
    issue32(5'h16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 32, "REM_neg");
    issue32(5'h15, 32'd100,      32'd7,        32'd14,       33, 32, "DIVU");
    issue32(5'h17, 32'd100,      32'd7,        32'd2,        33, 32, "REMU");
    issue32(5'h14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 32, "DIV_negb");
    issue32(5'h16, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 32, "REM_negb");
    issue32(5'h14, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, "DIV_by0");
    issue32(5'h16, 32'd5,        32'd0,        32'd5,        1, 0, "REM_by0");
    issue32(5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "DIV_ovf");
    issue32(5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 0, "REM_ovf");
    drain();

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    issue32(5'h00, 32'd3, 32'd4, 32'd7, 1, 0, "ADD_bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp out_result", 64'(out_result), 64'd7);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    issue32(5'h00, 32'd1, 32'd2, 32'd3, 1, 0, "ADD_after_bp");
    drain();

    // Flush during a divide: no result may appear.
    issue32(5'h15, 32'd1000, 32'd3, 32'd0, 0, 0, "DIVU_flushed", 1'b0);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    issue32(5'h00, 32'd10, 32'd20, 32'd30, 1, 0, "ADD_after_flush");
    drain();

    // Reset mid-multiply: outputs return to reset values without a clock edge.
    issue32(5'h10, 32'd3, 32'd5, 32'd0, 0, 0, "MUL_reset", 1'b0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset out_result", 64'(out_result), 64'd0);
    chk("midreset out_zero", 64'(out_zero), 64'd1);
    chk("midreset busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue32(5'h10, 32'd3, 32'd5, 32'd15, 33, 32, "MUL_after_reset");
    drain();

    // 64-bit build.
    issue64(5'h13, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65, 64, "MULHU64");
    issue64(5'h10, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h1, 65, 64, "MUL64");
    issue64(5'h05, 64'h1, 64'd63, 64'h8000000000000000, 1, 0, "SLL64_63");
    issue64(5'h05, 64'h1, 64'd65, 64'h2, 1, 0, "SLL64_mask");
    issue64(5'h14, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65, 64, "DIV64");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
